// File: rtl/mult_32bit.sv
// Three-stage pipelined signed 32x32 -> 64-bit multiplier with valid qualifier.
// Optional ovf32 output (product outside signed 32-bit range) under MULT_OVF32_FLAG_EN.
module mult_32bit #(
    parameter int unsigned LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [63:0] y
`ifdef MULT_OVF32_FLAG_EN
    ,
    output logic        ovf32
`endif
);

    localparam int unsigned W_OP   = 32;
    localparam int unsigned W_HALF = 16;
    localparam int unsigned W_PROD = 64;

    if (LATENCY != 3) begin : g_latency_check
        $error("mult_32bit: LATENCY must be 3");
    end

    // Stage 1: sign and unsigned magnitudes (|0x80000000| stays 0x80000000)
    logic              v1;
    logic              sign1;
    logic [W_OP-1:0]   mag_a;
    logic [W_OP-1:0]   mag_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            sign1 <= 1'b0;
            mag_a <= '0;
            mag_b <= '0;
        end else begin
            v1    <= in_valid;
            sign1 <= a[W_OP-1] ^ b[W_OP-1];
            mag_a <= a[W_OP-1] ? W_OP'(~a + 32'd1) : a;
            mag_b <= b[W_OP-1] ? W_OP'(~b + 32'd1) : b;
        end
    end

    // Stage 2: four 16x16 partial products; sign rides alongside
    logic              v2;
    logic              sign2;
    logic [W_OP-1:0]   pp_ll;
    logic [W_OP-1:0]   pp_lh;
    logic [W_OP-1:0]   pp_hl;
    logic [W_OP-1:0]   pp_hh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            sign2 <= 1'b0;
            pp_ll <= '0;
            pp_lh <= '0;
            pp_hl <= '0;
            pp_hh <= '0;
        end else begin
            v2    <= v1;
            sign2 <= sign1;
            pp_ll <= W_OP'(mag_a[W_HALF-1:0])    * W_OP'(mag_b[W_HALF-1:0]);
            pp_lh <= W_OP'(mag_a[W_HALF-1:0])    * W_OP'(mag_b[W_OP-1:W_HALF]);
            pp_hl <= W_OP'(mag_a[W_OP-1:W_HALF]) * W_OP'(mag_b[W_HALF-1:0]);
            pp_hh <= W_OP'(mag_a[W_OP-1:W_HALF]) * W_OP'(mag_b[W_OP-1:W_HALF]);
        end
    end

    // Stage 3: accumulate shifted partials, then apply sign (negating 0 gives 0)
    logic [W_PROD-1:0] mag_sum;
    logic [W_PROD-1:0] prod;

    always_comb begin
        mag_sum = {32'd0, pp_ll}
                + {16'd0, pp_lh, 16'd0}
                + {16'd0, pp_hl, 16'd0}
                + {pp_hh, 32'd0};
        prod    = sign2 ? W_PROD'(~mag_sum + 64'd1) : mag_sum;
    end

`ifdef MULT_OVF32_FLAG_EN
    logic ovf_c;
    assign ovf_c = (prod[W_PROD-1:W_OP-1] != {33{prod[W_OP-1]}});
`endif

    // Output register: y (and ovf32) hold while no new product arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
`ifdef MULT_OVF32_FLAG_EN
            ovf32     <= 1'b0;
`endif
        end else begin
            out_valid <= v2;
            if (v2) begin
                y     <= prod;
`ifdef MULT_OVF32_FLAG_EN
                ovf32 <= ovf_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mult_32bit.sv
// Directed and random self-checking bench for mult_32bit.
module tb_mult_32bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [63:0] y;
`ifdef MULT_OVF32_FLAG_EN
    logic        ovf32;
`endif

    int checks   = 0;
    int failures = 0;
    logic [63:0] last_y = 64'd0;

    mult_32bit #(.LATENCY(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .y         (y)
`ifdef MULT_OVF32_FLAG_EN
        ,
        .ovf32     (ovf32)
`endif
    );

    always #5 clk = ~clk;

    // Hand-computed directed table
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [63:0] vy [6];

    initial begin
        va[0] = 32'd4;          vb[0] = 32'd6;          vy[0] = 64'd24;
        va[1] = 32'd0;          vb[1] = 32'hFFFFFFFF;   vy[1] = 64'd0;
        va[2] = 32'h7FFFFFFF;   vb[2] = 32'h7FFFFFFF;   vy[2] = 64'd4611686014132420609;
        va[3] = 32'h80000000;   vb[3] = 32'h7FFFFFFF;   vy[3] = 64'hC000000080000000;
        va[4] = 32'h7FFFFFFF;   vb[4] = 32'h80000000;   vy[4] = 64'hC000000080000000;
        va[5] = 32'h80000000;   vb[5] = 32'h80000000;   vy[5] = 64'd4611686018427387904;
    end

    // Single op: drive on a negedge, return on the negedge after the 3rd rising edge
    task automatic do_op(input logic [31:0] x, input logic [31:0] z);
        @(negedge clk);
        in_valid = 1'b1; a = x; b = z;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || y !== 64'd0) begin
            failures++;
            $display("FAIL reset_init out_valid=%b y=%h exp 0/0", out_valid, y);
        end
        @(negedge clk); rst = 1'b0;
        // Launch an op, then two more in flight, and reset while out_valid=1
        @(negedge clk); in_valid = 1'b1; a = 32'd4; b = 32'd6;
        @(negedge clk); a = 32'd7; b = 32'd9;
        @(negedge clk); a = 32'd3; b = 32'd5;
        @(negedge clk); in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || y !== 64'd24) begin
            failures++;
            $display("FAIL reset_pre out_valid=%b y=%h exp 1/%h", out_valid, y, 64'd24);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || y !== 64'd0) begin
            failures++;
            $display("FAIL reset_async out_valid=%b y=%h exp 0/0", out_valid, y);
        end
        @(negedge clk); rst = 1'b0;
        last_y = 64'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || y !== 64'd0) begin
                failures++;
                $display("FAIL reset_stale[%0d] out_valid=%b y=%h exp 0/0", i, out_valid, y);
            end
        end
    endtask

    task automatic test_directed;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i]);
            checks++;
            if (out_valid !== 1'b1 || y !== vy[i]) begin
                failures++;
                $display("FAIL directed[%0d] out_valid=%b y=%h exp 1/%h", i, out_valid, y, vy[i]);
            end
            last_y = vy[i];
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || y !== vy[i]) begin
                failures++;
                $display("FAIL directed_hold[%0d] out_valid=%b y=%h exp 0/%h", i, out_valid, y, vy[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (cyc >= 3 && cyc < 9) begin
                checks++;
                if (out_valid !== 1'b1 || y !== vy[cyc-3]) begin
                    failures++;
                    $display("FAIL b2b[%0d] out_valid=%b y=%h exp 1/%h", cyc-3, out_valid, y, vy[cyc-3]);
                end
                last_y = vy[cyc-3];
            end else if (cyc == 9) begin
                checks++;
                if (out_valid !== 1'b0 || y !== last_y) begin
                    failures++;
                    $display("FAIL b2b_end out_valid=%b y=%h exp 0/%h", out_valid, y, last_y);
                end
            end
            if (cyc < 6) begin
                in_valid = 1'b1; a = va[cyc]; b = vb[cyc];
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_bubbles;
        logic       pat [5];
        logic [2:0] idx [5];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b0;
        idx[0] = 3'd3; idx[1] = 3'd5; idx[2] = 3'd2; idx[3] = 3'd0; idx[4] = 3'd5;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (cyc >= 3) begin
                checks++;
                if (pat[cyc-3]) begin
                    if (out_valid !== 1'b1 || y !== vy[idx[cyc-3]]) begin
                        failures++;
                        $display("FAIL bubble[%0d] out_valid=%b y=%h exp 1/%h", cyc-3, out_valid, y, vy[idx[cyc-3]]);
                    end
                    last_y = vy[idx[cyc-3]];
                end else if (out_valid !== 1'b0 || y !== last_y) begin
                    failures++;
                    $display("FAIL bubble[%0d] out_valid=%b y=%h exp 0/%h", cyc-3, out_valid, y, last_y);
                end
            end
            if (cyc < 5) begin
                in_valid = pat[cyc]; a = va[idx[cyc]]; b = vb[idx[cyc]];
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_random;
        localparam int N = 10000;
        longint exp_q [$];
        int     sa;
        int     sb;
        int     errs = 0;
        longint e;
        for (int cyc = 0; cyc < N + 3; cyc++) begin
            @(negedge clk);
            if (cyc >= 3) begin
                e = exp_q.pop_front();
                checks++;
                if (out_valid !== 1'b1 || y !== 64'(e)) begin
                    failures++;
                    errs++;
                    if (errs <= 10)
                        $display("FAIL random[%0d] out_valid=%b y=%h exp 1/%h", cyc-3, out_valid, y, 64'(e));
                end
                last_y = 64'(e);
            end
            if (cyc < N) begin
                // Bias some operands toward the extremes and zero
                case ($urandom_range(0, 7))
                    0:       sa = 32'h80000000;
                    1:       sa = 0;
                    default: sa = int'($urandom());
                endcase
                case ($urandom_range(0, 7))
                    0:       sb = 32'h80000000;
                    1:       sb = -1;
                    default: sb = int'($urandom());
                endcase
                in_valid = 1'b1; a = 32'(sa); b = 32'(sb);
                exp_q.push_back(longint'(sa) * longint'(sb));
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

`ifdef MULT_OVF32_FLAG_EN
    task automatic test_ovf32;
        do_op(32'd65536, 32'd32768);
        checks++;
        if (out_valid !== 1'b1 || ovf32 !== 1'b1 || y !== 64'h0000000080000000) begin
            failures++;
            $display("FAIL ovf_pos ovf32=%b y=%h exp 1/%h", ovf32, y, 64'h0000000080000000);
        end
        do_op(32'hFFFF0000, 32'd32768);
        checks++;
        if (out_valid !== 1'b1 || ovf32 !== 1'b0 || y !== 64'hFFFFFFFF80000000) begin
            failures++;
            $display("FAIL ovf_minint ovf32=%b y=%h exp 0/%h", ovf32, y, 64'hFFFFFFFF80000000);
        end
        do_op(32'd4, 32'd6);
        checks++;
        if (out_valid !== 1'b1 || ovf32 !== 1'b0 || y !== 64'd24) begin
            failures++;
            $display("FAIL ovf_small ovf32=%b y=%h exp 0/%h", ovf32, y, 64'd24);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_bubbles();
        test_random();
`ifdef MULT_OVF32_FLAG_EN
        test_ovf32();
`endif
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
